// File: rtl/console_writer_pkg.sv
// Display constants shared by the console writer slice.
// Text geometry, word packing, the VGA character-region base address and the
// control codes the writer interprets. A helper replicates one character across
// every lane of a memory word.
package console_writer_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned ASCII_SIZE = 8;
    localparam int unsigned CHARS_HORZ = 80;
    localparam int unsigned CHARS_VERT = 30;

    localparam logic [WORD_SIZE-1:0] VGA_MEM_OFFSET = 32'h0001_0000;

    localparam int unsigned CHARS_PER_WORD = WORD_SIZE / ASCII_SIZE;
    localparam int unsigned WORDS_PER_ROW  = CHARS_HORZ / CHARS_PER_WORD;
    localparam int unsigned TOTAL_WORDS    = CHARS_VERT * WORDS_PER_ROW;

    localparam int unsigned ROW_W = $clog2(CHARS_VERT);
    localparam int unsigned COL_W = $clog2(CHARS_HORZ);

    localparam logic [ASCII_SIZE-1:0] ASCII_LF    = 8'h0A;
    localparam logic [ASCII_SIZE-1:0] ASCII_CR    = 8'h0D;
    localparam logic [ASCII_SIZE-1:0] ASCII_BS    = 8'h08;
    localparam logic [ASCII_SIZE-1:0] ASCII_FF    = 8'h0C;
    localparam logic [ASCII_SIZE-1:0] ASCII_SPACE = 8'h20;

    function automatic logic [WORD_SIZE-1:0] replicate(input logic [ASCII_SIZE-1:0] c);
        return {CHARS_PER_WORD{c}};
    endfunction

endpackage

// File: rtl/console_writer_if.sv
// Character input handshake, memory write port and cursor readback of the
// console writer.
//   master : the console writer (accepts chars, drives the memory write port)
//   slave  : the environment (CPU IO-out port plus memory)
interface console_writer_if;
    import console_writer_pkg::*;

    logic [ASCII_SIZE-1:0]     charIn;
    logic                      charValid;
    logic                      charReady;
    logic                      memWrEn;
    logic [WORD_SIZE-1:0]      memWrAdd;
    logic [WORD_SIZE-1:0]      memDataWrite;
    logic [CHARS_PER_WORD-1:0] memByteEn;
    logic [ROW_W-1:0]          cursorRow;
    logic [COL_W-1:0]          cursorCol;

    modport master (
        input  charIn, charValid,
        output charReady, memWrEn, memWrAdd, memDataWrite, memByteEn, cursorRow, cursorCol
    );

    modport slave (
        output charIn, charValid,
        input  charReady, memWrEn, memWrAdd, memDataWrite, memByteEn, cursorRow, cursorCol
    );

endinterface

// File: rtl/console_writer_cursor_ctrl.sv
// Cursor register for the console writer.
// Ports: clk/reset (sync, active high); one-cycle commands advance_i, newline_i,
// carriage_i, back_i, home_i (home has priority); row_o/col_o current cursor;
// row_next_o the row after this cycle's command; row_advanced_o set when this
// cycle's command moves to a new row.
module console_writer_cursor_ctrl
    import console_writer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             advance_i,
    input  logic             newline_i,
    input  logic             carriage_i,
    input  logic             back_i,
    input  logic             home_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_next_o,
    output logic             row_advanced_o
);

    logic [ROW_W-1:0] row_q, row_d, row_wrap;
    logic [COL_W-1:0] col_q, col_d;

    assign row_wrap = (row_q == ROW_W'(CHARS_VERT - 1)) ? '0 : row_q + ROW_W'(1);

    always_comb begin
        row_d          = row_q;
        col_d          = col_q;
        row_advanced_o = 1'b0;
        if (home_i) begin
            row_d = '0;
            col_d = '0;
        end else if (newline_i) begin
            col_d          = '0;
            row_d          = row_wrap;
            row_advanced_o = 1'b1;
        end else if (advance_i) begin
            if (col_q == COL_W'(CHARS_HORZ - 1)) begin
                col_d          = '0;
                row_d          = row_wrap;
                row_advanced_o = 1'b1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else if (carriage_i) begin
            col_d = '0;
        end else if (back_i && col_q != '0) begin
            col_d = col_q - COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign row_next_o = row_d;

endmodule

// File: rtl/console_writer.sv
// Character-stream writer for the VGA text buffer.
// Ports: clk, reset (sync, active high); bus (console_writer_if.master) carries
// the charIn/charValid/charReady handshake, the registered byte-masked memory
// write port (memWrEn/memWrAdd/memDataWrite/memByteEn) and the cursor position.
// After reset the whole character region is cleared to spaces, then one char is
// accepted per handshake. A row advance clears the new row before accepting more.
module console_writer #(
    parameter int unsigned CHARS_PER_WORD = console_writer_pkg::CHARS_PER_WORD,
    parameter int unsigned WORDS_PER_ROW  = console_writer_pkg::WORDS_PER_ROW
) (
    input logic               clk,
    input logic               reset,
    console_writer_if.master  bus
);
    import console_writer_pkg::WORD_SIZE, console_writer_pkg::CHARS_HORZ;
    import console_writer_pkg::CHARS_VERT, console_writer_pkg::VGA_MEM_OFFSET;
    import console_writer_pkg::ROW_W, console_writer_pkg::COL_W;
    import console_writer_pkg::ASCII_LF, console_writer_pkg::ASCII_CR;
    import console_writer_pkg::ASCII_BS, console_writer_pkg::ASCII_FF;
    import console_writer_pkg::ASCII_SPACE, console_writer_pkg::replicate;

    localparam int unsigned TotalWords = CHARS_VERT * WORDS_PER_ROW;
    localparam int unsigned CntW       = $clog2(TotalWords);
    localparam logic [CHARS_PER_WORD-1:0] LaneMsb = {1'b1, {(CHARS_PER_WORD - 1){1'b0}}};
    localparam logic [WORD_SIZE-1:0] SpaceWord = replicate(ASCII_SPACE);

    typedef enum logic [1:0] {StClearAll, StIdle, StClearRow} state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      wr_en_q, wr_en_d;
    logic [WORD_SIZE-1:0]      wr_add_q, wr_add_d;
    logic [WORD_SIZE-1:0]      wr_data_q, wr_data_d;
    logic [CHARS_PER_WORD-1:0] wr_be_q, wr_be_d;
    logic                      ready_q, ready_d;

    logic                      accept, printable;
    logic                      cmd_adv, cmd_nl, cmd_cr, cmd_back, cmd_home;
    logic [ROW_W-1:0]          row, row_next;
    logic [COL_W-1:0]          col;
    logic                      row_advanced;
    logic [WORD_SIZE-1:0]      cur_pos, back_pos, row_base, next_row_base;

    assign accept    = bus.charValid && ready_q && (state_q == StIdle);
    assign printable = (bus.charIn >= 8'h20) && (bus.charIn <= 8'h7E);

    assign cur_pos       = WORD_SIZE'(row) * WORD_SIZE'(CHARS_HORZ) + WORD_SIZE'(col);
    assign back_pos      = cur_pos - WORD_SIZE'(1);
    assign row_base      = WORD_SIZE'(row) * WORD_SIZE'(WORDS_PER_ROW);
    assign next_row_base = WORD_SIZE'(row_next) * WORD_SIZE'(WORDS_PER_ROW);

    // Command decode is kept apart from the datapath, which reads the cursor's
    // next-row result for the first LF clear write.
    always_comb begin
        cmd_adv  = 1'b0;
        cmd_nl   = 1'b0;
        cmd_cr   = 1'b0;
        cmd_back = 1'b0;
        cmd_home = 1'b0;
        if (accept) begin
            if (printable) begin
                cmd_adv = 1'b1;
            end else begin
                case (bus.charIn)
                    ASCII_LF: cmd_nl   = 1'b1;
                    ASCII_CR: cmd_cr   = 1'b1;
                    ASCII_BS: cmd_back = 1'b1;
                    ASCII_FF: cmd_home = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    console_writer_cursor_ctrl u_cursor (
        .clk            (clk),
        .reset          (reset),
        .advance_i      (cmd_adv),
        .newline_i      (cmd_nl),
        .carriage_i     (cmd_cr),
        .back_i         (cmd_back),
        .home_i         (cmd_home),
        .row_o          (row),
        .col_o          (col),
        .row_next_o     (row_next),
        .row_advanced_o (row_advanced)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_add_d  = '0;
        wr_data_d = '0;
        wr_be_d   = '0;
        case (state_q)
            StClearAll: begin
                wr_en_d   = 1'b1;
                wr_add_d  = VGA_MEM_OFFSET + WORD_SIZE'(cnt_q);
                wr_data_d = SpaceWord;
                wr_be_d   = '1;
                if (cnt_q == CntW'(TotalWords - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                if (cmd_adv) begin
                    wr_en_d   = 1'b1;
                    wr_add_d  = VGA_MEM_OFFSET + cur_pos / CHARS_PER_WORD;
                    wr_data_d = replicate(bus.charIn);
                    wr_be_d   = LaneMsb >> (cur_pos % CHARS_PER_WORD);
                    if (row_advanced) begin
                        cnt_d   = '0;
                        state_d = StClearRow;
                    end
                end else if (cmd_nl) begin
                    // LF has no char write, so the first clear goes out right away.
                    wr_en_d   = 1'b1;
                    wr_add_d  = VGA_MEM_OFFSET + next_row_base;
                    wr_data_d = SpaceWord;
                    wr_be_d   = '1;
                    cnt_d     = CntW'(1);
                    state_d   = (WORDS_PER_ROW > 1) ? StClearRow : StIdle;
                end else if (cmd_back && col != '0) begin
                    wr_en_d   = 1'b1;
                    wr_add_d  = VGA_MEM_OFFSET + back_pos / CHARS_PER_WORD;
                    wr_data_d = SpaceWord;
                    wr_be_d   = LaneMsb >> (back_pos % CHARS_PER_WORD);
                end else if (cmd_home) begin
                    cnt_d   = '0;
                    state_d = StClearAll;
                end
            end
            StClearRow: begin
                wr_en_d   = 1'b1;
                wr_add_d  = VGA_MEM_OFFSET + row_base + WORD_SIZE'(cnt_q);
                wr_data_d = SpaceWord;
                wr_be_d   = '1;
                if (cnt_q == CntW'(WORDS_PER_ROW - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StClearAll;
            end
        endcase
    end

    // Ready needs a full idle cycle behind it: it drops the cycle after an
    // accept that leaves IDLE and rises one cycle after the last clear write.
    assign ready_d = (state_q == StIdle) && (state_d == StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClearAll;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_add_q  <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_add_q  <= wr_add_d;
            wr_data_q <= wr_data_d;
            wr_be_q   <= wr_be_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.charReady    = ready_q;
    assign bus.memWrEn      = wr_en_q;
    assign bus.memWrAdd     = wr_add_q;
    assign bus.memDataWrite = wr_data_q;
    assign bus.memByteEn    = wr_be_q;
    assign bus.cursorRow    = row;
    assign bus.cursorCol    = col;

endmodule

// File: tb/tb_console_writer.sv
module tb_console_writer;
    import console_writer_pkg::*;

    localparam logic [31:0] O      = VGA_MEM_OFFSET;
    localparam logic [31:0] SPACES = 32'h2020_2020;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    console_writer_if bus ();

    console_writer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;
    int  m_row   = 0;
    int  m_col   = 0;
    wr_t exp_q[$];

    // Scoreboard: every write seen on the memory port must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.memWrEn) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h be %b, required no write",
                             bus.memWrAdd, bus.memDataWrite, bus.memByteEn);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (bus.memWrAdd !== e.addr || bus.memDataWrite !== e.data ||
                        bus.memByteEn !== e.be) begin
                        n_fail++;
                        $display("FAIL write: got addr %h data %h be %b, required addr %h data %h be %b",
                                 bus.memWrAdd, bus.memDataWrite, bus.memByteEn,
                                 e.addr, e.data, e.be);
                    end
                end
            end else if (bus.memByteEn !== 4'b0000) begin
                n_tests++;
                n_fail++;
                $display("FAIL idle_byte_en: got %b, required 0000", bus.memByteEn);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.be   = be;
        exp_q.push_back(w);
    endtask

    task automatic expect_clear_row(input int r);
        for (int w = 0; w < 20; w++) expect_write(O + 32'(r * 20 + w), SPACES, 4'hF);
    endtask

    task automatic expect_clear_all();
        for (int i = 0; i < 600; i++) expect_write(O + 32'(i), SPACES, 4'hF);
    endtask

    // Called at a negedge; returns at the negedge after acceptance with charValid low.
    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        bus.charIn    = c;
        bus.charValid = 1'b1;
        while (!bus.charReady && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.charReady) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got charReady 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        @(negedge clk);
        bus.charValid = 1'b0;
    endtask

    // Reference console behaviour, used to build setup traffic.
    task automatic model_send(input logic [7:0] c);
        int pos;
        if (c >= 8'h20 && c <= 8'h7E) begin
            pos = m_row * 80 + m_col;
            expect_write(O + 32'(pos / 4), {4{c}}, 4'b1000 >> (pos % 4));
            if (m_col == 79) begin
                m_col = 0;
                m_row = (m_row + 1) % 30;
                expect_clear_row(m_row);
            end else begin
                m_col++;
            end
        end else if (c == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % 30;
            expect_clear_row(m_row);
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                pos = m_row * 80 + m_col;
                expect_write(O + 32'(pos / 4), SPACES, 4'b1000 >> (pos % 4));
            end
        end else if (c == 8'h0C) begin
            m_row = 0;
            m_col = 0;
            expect_clear_all();
        end
        send_char(c);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: got %0d writes pending, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        n_tests++;
        if (bus.cursorRow !== ROW_W'(r) || bus.cursorCol !== COL_W'(c)) begin
            n_fail++;
            $display("FAIL cursor_%s: got (%0d,%0d), required (%0d,%0d)",
                     name, bus.cursorRow, bus.cursorCol, r, c);
        end
    endtask

    task automatic test_reset();
        int n;
        int run;
        mon_en        = 1'b0;
        reset         = 1'b1;
        bus.charValid = 1'b0;
        bus.charIn    = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.memWrEn !== 1'b0 || bus.memByteEn !== 4'b0000 || bus.memWrAdd !== 32'h0 ||
            bus.memDataWrite !== 32'h0 || bus.charReady !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en %b be %b add %h data %h ready %b, required all 0",
                     bus.memWrEn, bus.memByteEn, bus.memWrAdd, bus.memDataWrite, bus.charReady);
        end
        check_cursor("reset", 0, 0);
        expect_clear_all();
        mon_en = 1'b1;
        reset  = 1'b0;
        n = 0;
        while (!bus.memWrEn && n < 10) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        while (bus.memWrEn && run < 700) begin
            run++;
            @(negedge clk);
        end
        n_tests++;
        if (run != 600) begin
            n_fail++;
            $display("FAIL clear_all_run: got %0d consecutive writes, required 600", run);
        end
        n_tests++;
        if (bus.charReady !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_clear: got %b, required 1", bus.charReady);
        end
        wait_drain("reset", 50);
        check_cursor("after_clear", 0, 0);
        m_row = 0;
        m_col = 0;
    endtask

    task automatic test_back_to_back();
        expect_write(O, 32'h4141_4141, 4'b1000);
        expect_write(O, 32'h4242_4242, 4'b0100);
        send_char(8'h41);
        n_tests++;
        if (bus.memWrEn !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_A: got memWrEn %b, required 1", bus.memWrEn);
        end
        send_char(8'h42);
        n_tests++;
        if (bus.memWrEn !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_B: got memWrEn %b, required 1", bus.memWrEn);
        end
        wait_drain("ab", 20);
        check_cursor("ab", 0, 2);
        m_col = 2;
    endtask

    task automatic test_control_codes();
        send_char(8'h01);
        repeat (3) @(negedge clk);
        check_cursor("ignored", 0, 2);
        send_char(8'h0D);
        repeat (2) @(negedge clk);
        check_cursor("cr", 0, 0);
        m_col = 0;
        wait_drain("ctrl", 5);
    endtask

    task automatic test_row_advance();
        for (int i = 0; i < 79; i++) model_send(8'h78);
        expect_write(O + 32'd19, 32'h7878_7878, 4'b0001);
        expect_clear_row(1);
        n_tests++;
        if (bus.charReady !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_80th: got %b, required 1", bus.charReady);
        end
        bus.charIn    = 8'h78;
        bus.charValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.charValid = 1'b0;
        for (int i = 0; i < 21; i++) begin
            n_tests++;
            if (bus.charReady !== 1'b0 || bus.memWrEn !== 1'b1) begin
                n_fail++;
                $display("FAIL row_adv_cycle%0d: got ready %b wr %b, required ready 0 wr 1",
                         i + 1, bus.charReady, bus.memWrEn);
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus.charReady !== 1'b1 || bus.memWrEn !== 1'b0) begin
            n_fail++;
            $display("FAIL row_adv_end: got ready %b wr %b, required ready 1 wr 0",
                     bus.charReady, bus.memWrEn);
        end
        wait_drain("row_adv", 10);
        check_cursor("row_adv", 1, 0);
        m_row = 1;
        m_col = 0;
    endtask

    task automatic test_lf_wrap();
        for (int i = 0; i < 28; i++) model_send(8'h0A);
        for (int i = 0; i < 5; i++) model_send(8'h61);
        wait_drain("lf_setup", 100);
        check_cursor("lf_setup", 29, 5);
        expect_clear_row(0);
        bus.charIn    = 8'h0A;
        bus.charValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.charValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (bus.memWrEn !== 1'b1) begin
                n_fail++;
                $display("FAIL lf_clear_cycle%0d: got wr %b, required 1", i + 1, bus.memWrEn);
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus.memWrEn !== 1'b0) begin
            n_fail++;
            $display("FAIL lf_clear_end: got wr %b, required 0", bus.memWrEn);
        end
        wait_drain("lf", 10);
        check_cursor("lf_wrap", 0, 0);
        m_row = 0;
        m_col = 0;
    endtask

    task automatic test_backspace();
        for (int i = 0; i < 3; i++) model_send(8'h0A);
        wait_drain("bs_setup", 100);
        check_cursor("bs_setup", 3, 0);
        send_char(8'h08);
        repeat (3) @(negedge clk);
        check_cursor("bs_col0", 3, 0);
        expect_write(O + 32'd60, 32'h5151_5151, 4'b1000);
        send_char(8'h51);
        expect_write(O + 32'd60, SPACES, 4'b1000);
        send_char(8'h08);
        wait_drain("bs", 10);
        check_cursor("bs", 3, 0);
    endtask

    task automatic test_form_feed();
        model_send(8'h5A);
        model_send(8'h0C);
        wait_drain("ff", 800);
        check_cursor("ff", 0, 0);
        n_tests++;
        if (bus.charReady !== 1'b1) begin
            n_fail++;
            $display("FAIL ff_ready: got %b, required 1", bus.charReady);
        end
    endtask

    task automatic test_reset_mid_clear();
        model_send(8'h0A);
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cursor("mid_reset", 0, 0);
        n_tests++;
        if (bus.memWrEn !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_wr: got %b, required 0", bus.memWrEn);
        end
        expect_clear_all();
        mon_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.memWrEn !== 1'b1 || bus.memWrAdd !== O) begin
            n_fail++;
            $display("FAIL mid_reset_first: got wr %b addr %h, required wr 1 addr %h",
                     bus.memWrEn, bus.memWrAdd, O);
        end
        wait_drain("mid_reset", 800);
        check_cursor("mid_reset_end", 0, 0);
        m_row = 0;
        m_col = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_control_codes();
        test_row_advance();
        test_lf_wrap();
        test_backspace();
        test_form_feed();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/console_writer.md
# console_writer

Character-stream writer for the VGA text buffer in main memory; the producer side of the display path whose consumer fetches packed character words from `gc::VGA_MEM_OFFSET`. Accepts one ASCII character per handshake from the IO port, tracks a cursor, interprets a small set of control codes, and issues byte-masked word writes into the character region. Sits between the CPU IO-out port and the memory write port, in the same clock domain as the system clock.

## Interface
- `CHARS_PER_WORD`, default `gc::WORD_SIZE/ASCII_SIZE` (4): characters packed per memory word.
- `WORDS_PER_ROW`, default `CHARS_HORZ/CHARS_PER_WORD`: words per text row; `CHARS_HORZ` must be a multiple of `CHARS_PER_WORD`.
- `clk  in  1`: system clock. One clock.
- `reset  in  1`: synchronous, active-high reset.
- `charIn  in  ASCII_SIZE`: character code.
- `charValid  in  1`: `charIn` valid.
- `charReady  out  1`: block accepts `charIn` this cycle.
- `memWrEn  out  1`: memory write strobe; the memory accepts the write in the cycle it is asserted.
- `memWrAdd  out  gc::WORD_SIZE`: word address, absolute, including `gc::VGA_MEM_OFFSET`.
- `memDataWrite  out  gc::WORD_SIZE`: write data.
- `memByteEn  out  CHARS_PER_WORD`: lane enables; bit `CHARS_PER_WORD-1` covers bits `[WORD_SIZE-1 -: ASCII_SIZE]`.
- `cursorRow  out  $clog2(CHARS_VERT)`: current row.
- `cursorCol  out  $clog2(CHARS_HORZ)`: current column.

## Operation
- States: `CLEAR_ALL`, `IDLE`, `CLEAR_ROW`.
- Reset: `cursorRow=0`, `cursorCol=0`, `memWrEn=0`, `memByteEn=0`, `memWrAdd=0`, `memDataWrite=0`, `charReady=0`, state `CLEAR_ALL`, clear counter 0.
- `CLEAR_ALL`: one write per cycle of all-spaces (0x20 in every lane, all byte enables set) to words `0 … CHARS_VERT*WORDS_PER_ROW-1`; then go to `IDLE`. `charReady=0`.
- `IDLE`: `charReady=1`. Accept on `charValid && charReady`:
  - Printable (0x20–0x7E): write the char at the cursor. Word index `(row*CHARS_HORZ+col)/CHARS_PER_WORD`. Lane `col%CHARS_PER_WORD`, where lane 0 is the MSB byte. Only that lane's enable is set; the char is replicated on all lanes. Then `col+1`. At `col==CHARS_HORZ-1`: `col=0`, advance row.
  - LF 0x0A: `col=0`, advance row. No write.
  - CR 0x0D: `col=0`. No write.
  - BS 0x08: if `col>0`, `col-1` and write a space at the new position. At `col==0`, no-op.
  - FF 0x0C: cursor to (0,0), go to `CLEAR_ALL`.
  - All other codes: ignored. Accepted, no effect.
- Advance row: `row+1`, wrapping to 0 after `CHARS_VERT-1`. Then enter `CLEAR_ROW` for the new row: `WORDS_PER_ROW` space writes, then return to `IDLE`.
- The address is always `gc::VGA_MEM_OFFSET + word index`. Arithmetic is unsigned, computed at `gc::WORD_SIZE` width.

## Timing
- Write latency: the write for an accepted char appears registered in the cycle after acceptance.
- Throughput: one printable char per cycle while no row advance occurs.
- Row advance from a printable at the last column: the char's write happens in cycle N+1; `CLEAR_ROW` writes occupy N+2 … N+1+`WORDS_PER_ROW`. `charReady` goes low in cycle N+1 and returns high in the cycle after the last clear write.
- Row advance from LF: clear writes occupy N+1 … N+`WORDS_PER_ROW`.
- `charReady` is a registered function of state. No combinational path from `charValid` to `charReady`.
- `reset` asserted mid-clear or mid-write: the block aborts on the next edge, re-enters `CLEAR_ALL`, and homes the cursor. A partially cleared row is acceptable because `CLEAR_ALL` rewrites everything.
- `memWrEn` is low in every cycle with no write. `memByteEn` is 0 whenever `memWrEn=0`.

## Structure
- Add `CHARS_PER_WORD`, `WORDS_PER_ROW`, `TOTAL_WORDS`, and control codes `ASCII_LF`, `ASCII_CR`, `ASCII_BS`, `ASCII_FF`, `ASCII_SPACE` to `dispConsts.svh`. The state enum stays local.
- One sub-module, `cursor_ctrl`: holds row/col, implements advance/back/home, and flags `rowAdvanced`. The FSM and write datapath live in `console_writer`.

## Test plan
Parameters: 32-bit words, `CHARS_HORZ=80`, `CHARS_VERT=30`, offset `O`.
- Release reset → 600 consecutive writes of 0x20202020 with `memByteEn=4'b1111` at `O…O+599`, then `charReady=1`, cursor (0,0).
- Send "AB" → writes of (`O`, 0x41414141, 1000) then (`O`, 0x42424242, 0100); cursor (0,2).
- Send 80 × 'x' from (0,0) → the last write is at `O+19` with lane 0001. Then 20 space writes at `O+20…O+39`, with `charReady` low exactly during those cycles. Cursor ends at (1,0).
- Cursor (29,5), send LF → 20 clears at `O…O+19`; cursor (0,0).
- Cursor (3,0), send BS → no write, cursor unchanged. Then 'Q', BS → space write at `O+60` lane 1000, cursor (3,0).
- Mid-`CLEAR_ROW`, pulse `reset` → the next cycle is a write to `O` in `CLEAR_ALL`, and the cursor is (0,0).
